// File: rtl/complete_arbiter_if.sv
// Bundle of FU completion inputs, stall feedback and CDB-side completion lanes.
// Widths follow the global `N_WAY / `CDB_BITS macros.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

interface complete_arbiter_if #(
  parameter int N_FU    = 4,
  parameter int Q_DEPTH = 8
);
  localparam int NUM_W = $clog2(`N_WAY) + 1;
  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  logic [N_FU-1:0]                  fu_done_valid;
  logic [N_FU-1:0][`CDB_BITS-1:0]   fu_done_tag;
  logic [N_FU-1:0]                  fu_stall;
  logic [`N_WAY-1:0][`CDB_BITS-1:0] complete_dest_tag;
  logic [NUM_W-1:0]                 complete_num;
  logic [CNT_W-1:0]                 q_count;

  // master: the arbiter itself; slave: FUs plus the CDB consumer
  modport master (
    input  fu_done_valid, fu_done_tag,
    output fu_stall, complete_dest_tag, complete_num, q_count
  );
  modport slave (
    output fu_done_valid, fu_done_tag,
    input  fu_stall, complete_dest_tag, complete_num, q_count
  );
endinterface

// File: rtl/complete_arbiter.sv
// Collects completed dest tags from N_FU units into a circular FIFO and emits up to `N_WAY per cycle.
// Optional COMPLETE_BYPASS_EN: an empty FIFO forwards accepted tags to the lanes in the same cycle.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module complete_arbiter #(
  parameter int N_FU    = 4,
  parameter int Q_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  complete_arbiter_if.master cif
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_W = $clog2(`N_WAY) + 1;
  localparam int TAG_W = `CDB_BITS;

  typedef logic [TAG_W-1:0] tag_t;

  tag_t             entry [Q_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0]            pop;
  logic [CNT_W-1:0]            n_enq;
  logic [N_FU-1:0]             enq;
  logic [N_FU-1:0][PTR_W-1:0]  wr_idx;
  logic [N_FU-1:0]             stall;
  tag_t                        lane [`N_WAY];
  logic [NUM_W-1:0]            n_lane;
  int                          n_acc;
  int                          n_byp;
  int                          slots;
`ifdef COMPLETE_BYPASS_EN
  logic                        byp_ok;
`endif

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reset gates everything combinational so held entries never leak out during the reset cycle.
  always_comb begin
    pop    = '0;
    n_enq  = '0;
    enq    = '0;
    wr_idx = '0;
    stall  = '0;
    n_lane = '0;
    n_acc  = 0;
    n_byp  = 0;
    slots  = 0;
    for (int k = 0; k < `N_WAY; k++) lane[k] = '0;
`ifdef COMPLETE_BYPASS_EN
    byp_ok = 1'b0;
`endif
    if (!reset) begin
      pop = CNT_W'(min_int(int'(count), `N_WAY));
      for (int k = 0; k < `N_WAY; k++) begin
        if (k < int'(pop)) lane[k] = entry[PTR_W'(int'(head) + k)];
      end
      slots = Q_DEPTH - int'(count) + int'(pop);
`ifdef COMPLETE_BYPASS_EN
      byp_ok = (count == '0);
`endif
      // Lower FU index wins both buffer slots and bypass lanes.
      for (int i = 0; i < N_FU; i++) begin
        if (cif.fu_done_valid[i] && cif.fu_done_tag[i] != '0) begin
`ifdef COMPLETE_BYPASS_EN
          if (byp_ok && n_byp < `N_WAY) begin
            for (int k = 0; k < `N_WAY; k++) begin
              if (k == n_byp) lane[k] = cif.fu_done_tag[i];
            end
            n_byp = n_byp + 1;
          end else
`endif
          if (n_acc < slots) begin
            enq[i]    = 1'b1;
            wr_idx[i] = PTR_W'(int'(tail) + n_acc);
            n_acc     = n_acc + 1;
          end else begin
            stall[i]  = 1'b1;
          end
        end
      end
      n_enq  = CNT_W'(n_acc);
      n_lane = NUM_W'(int'(pop) + n_byp);
    end
  end

  // State register boundary: pointers/count update on the edge, pop and push in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(n_enq);
      count <= count - pop + n_enq;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (enq[i]) entry[wr_idx[i]] <= cif.fu_done_tag[i];
    end
  end

  always_comb begin
    for (int k = 0; k < `N_WAY; k++) cif.complete_dest_tag[k] = lane[k];
  end

  assign cif.fu_stall     = stall;
  assign cif.complete_num = n_lane;
  assign cif.q_count      = reset ? '0 : count;
endmodule
